sar_search_ctrl: RTL and testbench

//  Binary-search (successive-approximation) initiator for the magnitude comparator.

---
 rtl/sar_search_ctrl.sv | 128 ++++++++++++
 tb/tb_sar_search_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search initiator: drives trial values to a magnitude
// comparator's B operand and converges on the target held on operand A.
module sar_search_ctrl #(
  parameter int WIDTH    = 2,
  parameter int CMP_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int              CW       = (CMP_WAIT > 1) ? $clog2(CMP_WAIT) : 1;
  localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID0    = MAX >> 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(CMP_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_guess, w_guess_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_found, w_found_nxt;
  logic             r_err, w_err_nxt;

  logic             w_onehot;
  logic             w_at_edge;
  logic [WIDTH-1:0] w_lo_upd;
  logic [WIDTH-1:0] w_hi_upd;
  logic [WIDTH:0]   w_sum;

  assign w_onehot  = $onehot({cmp_eq, cmp_gt, cmp_lt});
  // A gt at max or lt at zero has nowhere left to go; caught before lo/hi would wrap.
  assign w_at_edge = (cmp_gt && (r_guess == MAX)) || (cmp_lt && (r_guess == '0));
  assign w_lo_upd  = cmp_gt ? r_guess + WIDTH'(1) : r_lo;
  assign w_hi_upd  = cmp_lt ? r_guess - WIDTH'(1) : r_hi;
  assign w_sum     = {1'b0, w_lo_upd} + {1'b0, w_hi_upd};

  always_comb begin
    // NOTE: every target gets its hold value first, so no path leaves one unassigned (no latch).
    w_state_nxt  = r_state;
    w_guess_nxt  = r_guess;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_result_nxt = r_result;
    w_cnt_nxt    = r_cnt;
    w_found_nxt  = r_found;
    w_err_nxt    = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lo_nxt     = '0;
          w_hi_nxt     = MAX;
          w_guess_nxt  = MID0;
          w_found_nxt  = 1'b0;
          w_err_nxt    = 1'b0;
          w_result_nxt = '0;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!w_onehot) begin
          w_err_nxt   = 1'b1;
          w_found_nxt = 1'b0;
          w_state_nxt = S_FIN;
        end else if (cmp_eq) begin
          w_result_nxt = r_guess;
          w_found_nxt  = 1'b1;
          w_state_nxt  = S_FIN;
        end else if (w_at_edge || (w_lo_upd > w_hi_upd)) begin
          w_state_nxt = S_FIN;
        end else begin
          w_lo_nxt    = w_lo_upd;
          w_hi_nxt    = w_hi_upd;
          w_guess_nxt = w_sum[WIDTH:1];
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_guess  <= '0;
      r_lo     <= '0;
      r_hi     <= MAX;
      r_result <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_guess  <= w_guess_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_result <= w_result_nxt;
      r_cnt    <= w_cnt_nxt;
      r_found  <= w_found_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign guess  = r_guess;
  assign busy   = (r_state == S_WAIT);
  assign done   = (r_state == S_FIN);
  assign found  = r_found;
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: a 2-bit/1-cycle instance and an 8-bit/3-cycle
// instance, each answered by a behavioural comparator that can be forced to fixed flags.
module tb_sar_search_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-bit, single-cycle comparator
  logic       a_start, a_eq, a_gt, a_lt, a_busy, a_done, a_found, a_err;
  logic [1:0] a_guess, a_result;
  int         a_tgt;
  bit         a_force;
  logic [2:0] a_ff;

  // 8-bit, three-cycle comparator
  logic       b_start, b_eq, b_gt, b_lt, b_busy, b_done, b_found, b_err;
  logic [7:0] b_guess, b_result;
  int         b_tgt;

  sar_search_ctrl #(.WIDTH(2), .CMP_WAIT(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .cmp_eq(a_eq), .cmp_gt(a_gt), .cmp_lt(a_lt),
    .guess(a_guess), .busy(a_busy), .done(a_done),
    .found(a_found), .err(a_err), .result(a_result)
  );

  sar_search_ctrl #(.WIDTH(8), .CMP_WAIT(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .cmp_eq(b_eq), .cmp_gt(b_gt), .cmp_lt(b_lt),
    .guess(b_guess), .busy(b_busy), .done(b_done),
    .found(b_found), .err(b_err), .result(b_result)
  );

  always_comb begin
    if (a_force) {a_eq, a_gt, a_lt} = a_ff;
    else begin
      a_eq = (a_tgt == int'(a_guess));
      a_gt = (a_tgt >  int'(a_guess));
      a_lt = (a_tgt <  int'(a_guess));
    end
    b_eq = (b_tgt == int'(b_guess));
    b_gt = (b_tgt >  int'(b_guess));
    b_lt = (b_tgt <  int'(b_guess));
  end

  // Selected-instance view used by the shared search driver.
  int   sel;
  int   m_guess, m_result;
  logic m_busy, m_done, m_found, m_err;
  always_comb begin
    m_guess  = sel == 0 ? int'(a_guess)  : int'(b_guess);
    m_result = sel == 0 ? int'(a_result) : int'(b_result);
    m_busy   = sel == 0 ? a_busy  : b_busy;
    m_done   = sel == 0 ? a_done  : b_done;
    m_found  = sel == 0 ? a_found : b_found;
    m_err    = sel == 0 ? a_err   : b_err;
  end

  int checks = 0;
  int errors = 0;
  int log_q[$];
  int log_cyc;
  int exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit seq_eq(input int x[$], input int y[$]);
    if (x.size() != y.size()) return 1'b0;
    foreach (x[i]) if (x[i] != y[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Starts a search, logs each distinct guess, and records edges from accept to done
  // (-1 if done never arrives within the budget). restart_at pulses start mid-search.
  task automatic run(input int s, input int tgt, input bit frc, input logic [2:0] ff,
                     input int restart_at);
    int prev;
    sel = s;
    if (s == 0) begin
      a_tgt = tgt; a_force = frc; a_ff = ff; a_start = 1'b1;
    end else begin
      b_tgt = tgt; b_start = 1'b1;
    end
    tick();
    a_start = 1'b0; b_start = 1'b0;
    log_q = {};
    log_q.push_back(m_guess);
    prev    = m_guess;
    log_cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == restart_at) begin
        if (s == 0) a_start = 1'b1; else b_start = 1'b1;
      end
      tick();
      a_start = 1'b0; b_start = 1'b0;
      if (m_done) begin
        log_cyc = k;
        break;
      end
      if (m_guess != prev) begin
        log_q.push_back(m_guess);
        prev = m_guess;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({a_guess, a_busy, a_done, a_found, a_err, a_result} !== 8'b0) begin
      errors++;
      $display("FAIL reset_a guess=%0d busy=%b done=%b found=%b err=%b result=%0d expected all 0",
               a_guess, a_busy, a_done, a_found, a_err, a_result);
    end
    checks++;
    if ({b_guess, b_busy, b_done, b_found, b_err, b_result} !== 20'b0) begin
      errors++;
      $display("FAIL reset_b guess=%0d busy=%b done=%b found=%b err=%b result=%0d expected all 0",
               b_guess, b_busy, b_done, b_found, b_err, b_result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_found();
    int tgts[4] = '{2, 0, 3, 1};
    int cycs[4] = '{2, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: exp_q = '{1, 2};
        1: exp_q = '{1, 0};
        2: exp_q = '{1, 2, 3};
        default: exp_q = '{1};
      endcase
      run(0, tgts[i], 1'b0, 3'b000, 0);
      checks++;
      if (!seq_eq(log_q, exp_q)) begin
        errors++;
        $display("FAIL found_seq t=%0d got %p expected %p", tgts[i], log_q, exp_q);
      end
      checks++;
      if (log_cyc != cycs[i]) begin
        errors++;
        $display("FAIL found_latency t=%0d got %0d expected %0d", tgts[i], log_cyc, cycs[i]);
      end
      checks++;
      if (m_found !== 1'b1 || m_err !== 1'b0 || m_busy !== 1'b0 || m_result != tgts[i]) begin
        errors++;
        $display("FAIL found_result t=%0d found=%b err=%b busy=%b result=%0d expected 1/0/0/%0d",
                 tgts[i], m_found, m_err, m_busy, m_result, tgts[i]);
      end
      tick();
    end
  endtask

  task automatic test_fin_hold();
    // target 2: done after the second edge; start presented while in FIN must be ignored
    run(0, 2, 1'b0, 3'b000, 0);
    checks++;
    if (log_cyc != 2 || a_done !== 1'b1) begin
      errors++;
      $display("FAIL fin_done cyc=%0d done=%b expected 2/1", log_cyc, a_done);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL fin_pulse done=%b busy=%b expected 0/0", a_done, a_busy);
    end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_found !== 1'b1 || a_result !== 2'd2 || a_guess !== 2'd2) begin
      errors++;
      $display("FAIL fin_hold busy=%b found=%b result=%0d guess=%0d expected 0/1/2/2",
               a_busy, a_found, a_result, a_guess);
    end
  endtask

  task automatic test_err();
    logic [2:0] pats[2] = '{3'b000, 3'b110};
    for (int i = 0; i < 2; i++) begin
      run(0, 0, 1'b1, pats[i], 0);
      checks++;
      if (log_cyc != 1 || log_q.size() != 1 || log_q[0] != 1) begin
        errors++;
        $display("FAIL err_probe flags=%b cyc=%0d seq=%p expected 1 / '{1}", pats[i], log_cyc, log_q);
      end
      checks++;
      if (m_err !== 1'b1 || m_found !== 1'b0 || m_result != 0) begin
        errors++;
        $display("FAIL err_flags flags=%b err=%b found=%b result=%0d expected 1/0/0",
                 pats[i], m_err, m_found, m_result);
      end
      tick();
    end
  endtask

  task automatic test_no_match();
    run(0, 0, 1'b1, 3'b010, 0);
    exp_q = '{1, 2, 3};
    checks++;
    if (!seq_eq(log_q, exp_q) || log_cyc != 3) begin
      errors++;
      $display("FAIL gt_always seq=%p cyc=%0d expected %p / 3", log_q, log_cyc, exp_q);
    end
    checks++;
    if (m_found !== 1'b0 || m_err !== 1'b0 || m_result != 0) begin
      errors++;
      $display("FAIL gt_always_out found=%b err=%b result=%0d expected 0/0/0", m_found, m_err, m_result);
    end
    tick();
    checks++;
    if (a_guess !== 2'd3) begin
      errors++;
      $display("FAIL gt_no_wrap guess=%0d expected 3", a_guess);
    end
    run(0, 0, 1'b1, 3'b001, 0);
    exp_q = '{1, 0};
    checks++;
    if (!seq_eq(log_q, exp_q) || log_cyc != 2 || m_found !== 1'b0 || m_err !== 1'b0) begin
      errors++;
      $display("FAIL lt_always seq=%p cyc=%0d found=%b err=%b expected %p / 2 / 0 / 0",
               log_q, log_cyc, m_found, m_err, exp_q);
    end
    tick();
    a_force = 1'b0;
  endtask

  task automatic test_wide_restart();
    run(1, 200, 1'b0, 3'b000, 5);
    exp_q = '{127, 191, 223, 207, 199, 203, 201, 200};
    checks++;
    if (!seq_eq(log_q, exp_q)) begin
      errors++;
      $display("FAIL wide_seq got %p expected %p", log_q, exp_q);
    end
    checks++;
    if (log_cyc != 24) begin
      errors++;
      $display("FAIL wide_latency got %0d expected 24", log_cyc);
    end
    checks++;
    if (b_found !== 1'b1 || b_err !== 1'b0 || b_result !== 8'd200) begin
      errors++;
      $display("FAIL wide_result found=%b err=%b result=%0d expected 1/0/200", b_found, b_err, b_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    sel = 1;
    b_tgt = 100; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (4) tick();
    checks++;
    if (b_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy busy=%b expected 1", b_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({b_guess, b_busy, b_done, b_found, b_err, b_result} !== 20'b0) begin
      errors++;
      $display("FAIL mid_reset guess=%0d busy=%b done=%b found=%b err=%b result=%0d expected all 0",
               b_guess, b_busy, b_done, b_found, b_err, b_result);
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (b_done || b_busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_abort done/busy seen in %0d cycles expected 0", pulses);
    end
    run(1, 255, 1'b0, 3'b000, 0);
    exp_q = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    checks++;
    if (!seq_eq(log_q, exp_q) || log_cyc != 27) begin
      errors++;
      $display("FAIL wide_max seq=%p cyc=%0d expected %p / 27", log_q, log_cyc, exp_q);
    end
    checks++;
    if (b_found !== 1'b1 || b_result !== 8'd255) begin
      errors++;
      $display("FAIL wide_max_result found=%b result=%0d expected 1/255", b_found, b_result);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_tgt = 0; b_tgt = 0; a_force = 1'b0; a_ff = 3'b000;
    sel = 0;
    test_reset();
    test_found();
    test_fin_hold();
    test_err();
    test_no_match();
    test_wide_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
